// File: rtl/embedding_table_loader.sv
// Runtime-writable embedding table: packs a stream of elements into VEC_LEN-wide rows,
// commits each row to consecutive indices, and serves a registered lookup read port.
module embedding_table_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_index,
  input  logic [ADDR_WIDTH:0]           num_rows,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic                          busy,
  output logic                          done,
  input  logic                          read_enable,
  input  logic [ADDR_WIDTH-1:0]         index,
  output logic [DATA_WIDTH*VEC_LEN-1:0] data_out
);

  localparam int ROW_W = DATA_WIDTH * VEC_LEN;
  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0]      LAST_ELEM = CNT_W'(VEC_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   ONE_ROW   = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_elem_cnt;
  logic [ADDR_WIDTH:0]     r_rows_rem;
  logic [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [ROW_W-1:0]        r_row_buf;
  logic [ROW_W-1:0]        r_mem [DEPTH];

  logic w_xfer;
  logic w_row_last;
  logic w_last_row;

  assign w_xfer     = s_valid && (r_state == FILL);
  assign w_row_last = (r_elem_cnt == LAST_ELEM);
  assign w_last_row = (r_rows_rem == ONE_ROW);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (num_rows != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (w_xfer && w_row_last) begin
          w_next = WRITE;
        end
      end
      WRITE: begin
        busy   = 1'b1;
        w_next = w_last_row ? DONE : FILL;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Load bookkeeping: base/count are only captured from IDLE, so a stray start mid-load is harmless
  always_ff @(posedge clk) begin
    if (rst) begin
      r_elem_cnt <= '0;
      r_rows_rem <= '0;
      r_wr_ptr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && (num_rows != '0)) begin
            r_wr_ptr   <= base_index;
            r_rows_rem <= num_rows;
          end
        end
        FILL: begin
          if (w_xfer) begin
            r_elem_cnt <= w_row_last ? '0 : r_elem_cnt + 1'b1;
          end
        end
        WRITE: begin
          r_wr_ptr   <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
          r_rows_rem <= r_rows_rem - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_row_buf[int'(r_elem_cnt)*DATA_WIDTH +: DATA_WIDTH] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == WRITE) begin
      r_mem[r_wr_ptr] <= r_row_buf;
    end
  end

  // Nonblocking read of the array gives read-before-write on an index collision
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (read_enable) begin
      data_out <= r_mem[index];
    end else begin
      data_out <= '0;
    end
  end

endmodule
